jt6295_cmdseq: RTL and testbench

Parametrised command sequencer that drives the CPU-side write interface of a jt6295 ADPCM core from a loadable command memory. It also generates the jt6295 clock enable. It replaces ad-hoc per-bench write scripts with a synthesizable player usable in benches and in cores that need canned sound-command sequences. It sits between a host/loader and the jt6295 wrn/din/dout/cen pins.

---
 rtl/jt6295_cmdseq.sv | 172 +++++++++++++++++
 tb/tb_jt6295_cmdseq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jt6295_cmdseq.sv
// jt6295_cmdseq: plays a canned list of commands from a small loadable memory
// into the CPU-side write port of a jt6295 ADPCM core. Commands can write a
// byte, wait a number of time units, poll the channel-busy status, or finish.
// Also produces the free-running jt6295 clock enable.
module jt6295_cmdseq #(
  parameter int DEPTH   = 128,
  parameter int WRHOLD  = 128,
  parameter int WAITCYC = 1024,
  parameter int CENDIV  = 4,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          cen,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [9:0]    prog_data,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc,
  output logic          wrn,
  output logic [7:0]    din,
  input  logic [7:0]    chip_dout
);

  localparam int CCW = (CENDIV > 2) ? $clog2(CENDIV) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_WRITE, ST_WAIT, ST_POLL, ST_DONE
  } state_t;

  state_t        state;
  logic [CCW-1:0] cen_cnt;
  logic [9:0]    mem [DEPTH];
  logic [9:0]    rdata;
  logic [31:0]   cnt;
  logic [3:0]    dout_q;
  logic [3:0]    arg_q;
  logic          hit;
  logic [1:0]    poll_cnt;
  logic [8:0]    units;
  logic [31:0]   wait_load;
  logic          unused_dout;

  // Only the four channel-busy bits of the status byte matter here.
  assign unused_dout = ^chip_dout[7:4];

  // A wait argument of zero stands for the full 256 units.
  assign units     = (rdata[7:0] == 8'd0) ? 9'd256 : {1'b0, rdata[7:0]};
  assign wait_load = 32'(units) * 32'(WAITCYC) - 32'd1;

  // Clock-enable divider, free running and unaware of the sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cen_cnt <= '0;
      cen     <= 1'b0;
    end else if (cen_cnt == '0) begin
      cen_cnt <= CCW'(CENDIV - 1);
      cen     <= 1'b1;
    end else begin
      cen_cnt <= cen_cnt - 1'b1;
      cen     <= 1'b0;
    end
  end

  // Command memory: loader writes any time, the sequencer reads at pc.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
    rdata <= mem[pc];
  end

  // Status sample and its comparison against the poll mask, one stage each.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_q <= '0;
      hit    <= 1'b0;
    end else begin
      dout_q <= chip_dout[3:0];
      hit    <= (dout_q & arg_q) == 4'd0;
    end
  end

  // Sequencer FSM; abort overrides everything and drops back to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      pc       <= '0;
      wrn      <= 1'b1;
      din      <= '0;
      cnt      <= '0;
      arg_q    <= '0;
      poll_cnt <= '0;
    end else if (abort) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      pc    <= '0;
      wrn   <= 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_FETCH;
            pc    <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
          end
        end
        ST_FETCH: state <= ST_DECODE;
        ST_DECODE: begin
          case (rdata[9:8])
            2'b00: begin
              wrn   <= 1'b0;
              din   <= rdata[7:0];
              cnt   <= 32'(WRHOLD - 1);
              state <= ST_WRITE;
            end
            2'b01: begin
              cnt   <= wait_load;
              state <= ST_WAIT;
            end
            2'b10: begin
              arg_q    <= rdata[3:0];
              poll_cnt <= '0;
              state    <= ST_POLL;
            end
            default: begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end
          endcase
        end
        ST_WRITE: begin
          if (cnt == '0) begin
            wrn   <= 1'b1;
            pc    <= pc + 1'b1;
            state <= ST_FETCH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            pc    <= pc + 1'b1;
            state <= ST_FETCH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_POLL: begin
          // The first two clocks fill the sample/compare pipeline with
          // status seen inside this poll, so stale results are never used.
          if (poll_cnt == 2'd2) begin
            if (hit) begin
              pc    <= pc + 1'b1;
              state <= ST_FETCH;
            end
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jt6295_cmdseq.sv
// tb_jt6295_cmdseq: directed programs with a write-event scoreboard and a
// free-running clock-enable checker.
module tb_jt6295_cmdseq;

  localparam int DEPTH   = 8;
  localparam int WRHOLD  = 4;
  localparam int WAITCYC = 8;
  localparam int CENDIV  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen;
  logic       prog_we = 1'b0;
  logic [2:0] prog_addr = '0;
  logic [9:0] prog_data = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       busy;
  logic       done;
  logic [2:0] pc;
  logic       wrn;
  logic [7:0] din;
  logic [7:0] chip_dout = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n;
  int m;

  typedef struct {
    logic [7:0] d;
    int         at;
    int         len;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic prev_wrn = 1'b1;
  int   low_len  = 0;
  int   cur_len  = 0;

  jt6295_cmdseq #(
    .DEPTH(DEPTH), .WRHOLD(WRHOLD), .WAITCYC(WAITCYC), .CENDIV(CENDIV)
  ) dut (
    .clk(clk), .rst(rst), .cen(cen),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .start(start), .abort(abort), .busy(busy), .done(done), .pc(pc),
    .wrn(wrn), .din(din), .chip_dout(chip_dout)
  );

  always #5 clk = ~clk;

  // Count of clock edges since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic loadEntry(input int a, input logic [1:0] op, input logic [7:0] arg);
    prog_we   = 1'b1;
    prog_addr = 3'(a);
    prog_data = {op, arg};
    @(negedge clk);
    prog_we   = 1'b0;
  endtask

  task automatic applyStimulus(input logic s, input logic a, output int edge_no);
    start = s;
    abort = a;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    edge_no = cyc;
  endtask

  task automatic waitUntil(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pushWrite(input logic [7:0] d, input int at, input int len);
    exp_t x;
    x.d = d; x.at = at; x.len = len;
    sb.push_back(x);
  endtask

  // Monitor: pops an expected write on every wrn fall, checks its width on the
  // rise, and checks cen against the ideal divider every clock.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_wrn && !wrn) begin
        if (sb.size() == 0) begin
          checkOutput("sb_nonempty", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          checkOutput("write_din", int'(din), int'(e.d));
          checkOutput("write_time", cyc, e.at);
          cur_len = e.len;
        end
        low_len = 1;
      end else if (!prev_wrn && !wrn) begin
        low_len++;
      end else if (!prev_wrn && wrn) begin
        checkOutput("write_len", low_len, cur_len);
      end
    end
    checkOutput("cen", int'(cen), int'(!rst && cyc >= 1 && ((cyc - 1) % CENDIV) == 0));
    prev_wrn = wrn;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_pc", pc, 0);
    checkOutput("rst_wrn", wrn, 1);
    checkOutput("rst_din", din, 0);
    rst = 1'b0;

    $display("[TB] back-to-back writes then FINISH");
    loadEntry(0, 2'b00, 8'h78);
    loadEntry(1, 2'b00, 8'hc3);
    loadEntry(2, 2'b00, 8'h13);
    loadEntry(3, 2'b11, 8'h00);
    applyStimulus(1'b1, 1'b0, n);
    pushWrite(8'h78, n + 2, 4);
    pushWrite(8'hc3, n + 8, 4);
    pushWrite(8'h13, n + 14, 4);
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_done_clr", done, 0);
    waitUntil(n + 19);
    checkOutput("t1_done_early", done, 0);
    waitUntil(n + 20);
    checkOutput("t1_done", done, 1);
    checkOutput("t1_busy_off", busy, 0);
    checkOutput("t1_pc", pc, 3);

    $display("[TB] WAIT 3 then write");
    loadEntry(0, 2'b01, 8'd3);
    loadEntry(1, 2'b00, 8'h55);
    loadEntry(2, 2'b11, 8'h00);
    applyStimulus(1'b1, 1'b0, n);
    checkOutput("t2_done_clr", done, 0);
    pushWrite(8'h55, n + 28, 4);
    waitUntil(n + 34);
    checkOutput("t2_done", done, 1);
    checkOutput("t2_pc", pc, 2);

    $display("[TB] WAIT 0 means 256 units");
    loadEntry(0, 2'b01, 8'd0);
    applyStimulus(1'b1, 1'b0, n);
    pushWrite(8'h55, n + 2052, 4);
    waitUntil(n + 1000);
    checkOutput("t2b_busy", busy, 1);
    checkOutput("t2b_pc", pc, 0);
    waitUntil(n + 2058);
    checkOutput("t2b_done", done, 1);

    $display("[TB] POLL with status stall, then already clear");
    loadEntry(0, 2'b10, 8'h02);
    loadEntry(1, 2'b00, 8'h22);
    loadEntry(2, 2'b10, 8'h02);
    loadEntry(3, 2'b00, 8'h33);
    loadEntry(4, 2'b11, 8'h00);
    chip_dout = 8'h02;
    applyStimulus(1'b1, 1'b0, n);
    pushWrite(8'h22, n + 55, 4);
    pushWrite(8'h33, n + 66, 4);
    waitUntil(n + 40);
    checkOutput("t3_pc_stall", pc, 0);
    checkOutput("t3_busy", busy, 1);
    waitUntil(n + 50);
    chip_dout = 8'hFD;
    waitUntil(n + 72);
    checkOutput("t3_done", done, 1);
    checkOutput("t3_pc", pc, 4);
    chip_dout = 8'h00;

    $display("[TB] abort mid-write, start+abort, restart");
    loadEntry(0, 2'b00, 8'h78);
    loadEntry(1, 2'b00, 8'hc3);
    loadEntry(2, 2'b00, 8'h13);
    loadEntry(3, 2'b11, 8'h00);
    applyStimulus(1'b1, 1'b0, n);
    pushWrite(8'h78, n + 2, 2);
    waitUntil(n + 3);
    applyStimulus(1'b0, 1'b1, m);
    checkOutput("t4_wrn", wrn, 1);
    checkOutput("t4_busy", busy, 0);
    checkOutput("t4_done", done, 0);
    checkOutput("t4_pc", pc, 0);
    applyStimulus(1'b1, 1'b1, m);
    checkOutput("t4_both_busy", busy, 0);
    waitUntil(m + 4);
    checkOutput("t4_both_idle", busy, 0);
    checkOutput("t4_both_wrn", wrn, 1);
    applyStimulus(1'b1, 1'b0, n);
    pushWrite(8'h78, n + 2, 4);
    pushWrite(8'hc3, n + 8, 4);
    pushWrite(8'h13, n + 14, 4);
    waitUntil(n + 20);
    checkOutput("t4_rerun_done", done, 1);
    checkOutput("t4_rerun_pc", pc, 3);

    $display("[TB] program without FINISH wraps");
    for (int i = 0; i < DEPTH; i++) loadEntry(i, 2'b00, 8'(8'hA0 + i));
    applyStimulus(1'b1, 1'b0, n);
    for (int i = 0; i < 10; i++) pushWrite(8'(8'hA0 + (i % DEPTH)), n + 2 + 6 * i, 4);
    waitUntil(n + 20);
    applyStimulus(1'b1, 1'b0, m);
    waitUntil(n + 30);
    checkOutput("t5_busy", busy, 1);
    waitUntil(n + 44);
    checkOutput("t5_pc7", pc, 7);
    waitUntil(n + 50);
    checkOutput("t5_pc_wrap", pc, 0);
    waitUntil(n + 59);
    applyStimulus(1'b0, 1'b1, m);
    checkOutput("t5_abort_busy", busy, 0);
    checkOutput("t5_abort_pc", pc, 0);
    checkOutput("t5_abort_wrn", wrn, 1);

    $display("[TB] reset during a write");
    applyStimulus(1'b1, 1'b0, n);
    pushWrite(8'hA0, n + 2, 4);
    waitUntil(n + 3);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_wrn", wrn, 1);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_pc", pc, 0);
    checkOutput("t6_din", din, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
